// File: rtl/clock_pkg.sv
// clock_pkg: field widths, range limits and mode encoding shared by the time keeper
package clock_pkg;
  localparam int HR_W = 5;
  localparam int MIN_W = 6;
  localparam int SEC_W = 6;
  localparam logic [HR_W-1:0] MAX_HR = 5'd23;
  localparam logic [MIN_W-1:0] MAX_MIN = 6'd59;
  localparam logic [SEC_W-1:0] MAX_SEC = 6'd59;
  typedef enum logic [1:0] {PAUSE, RUN, SET} state_t;
  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
    return v == max ? 6'd0 : v + 6'd1;
  endfunction
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: one-cycle wrap strobe after every CLK_HZ enabled cycles
module tick_prescaler #(
  parameter int CLK_HZ = 100_000_000,
  parameter int CNT_W = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);
  logic [CNT_W-1:0] cnt;
  assign tick = en && cnt == CNT_W'(CLK_HZ - 1);
  // count enabled cycles; park at zero while disabled or when a load restarts the second
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= (!en || clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/time_keeper.sv
// time_keeper: 24-hour hr/min/sec keeper with 1 Hz prescaler, manual set and bulk load
module time_keeper
  import clock_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int CNT_W = 27
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_en,
  input  logic             set_mode,
  input  logic             inc_hr,
  input  logic             inc_min,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [HR_W-1:0]  load_hr,
  input  logic [MIN_W-1:0] load_min,
  input  logic [SEC_W-1:0] load_sec,
  output logic             load_err,
  output logic [HR_W-1:0]  hr,
  output logic [MIN_W-1:0] min,
  output logic [SEC_W-1:0] sec,
  output logic             tick_1hz,
  output logic             day_wrap
);
  state_t mode;
  logic wrap, xfer, load_ok, wrap_d;
  logic [HR_W-1:0] hr_d;
  logic [MIN_W-1:0] min_d;
  logic [SEC_W-1:0] sec_d;
  assign xfer = load_valid && load_ready;
  assign load_ok = load_hr <= MAX_HR && load_min <= MAX_MIN && load_sec <= MAX_SEC;
  // mode follows the level inputs every cycle, set_mode winning over run_en
  always_comb mode = set_mode ? SET : run_en ? RUN : PAUSE;
  tick_prescaler #(.CLK_HZ(CLK_HZ), .CNT_W(CNT_W)) u_pre (
    .clk(clk), .reset(reset), .en(mode == RUN), .clr(xfer && load_ok), .tick(wrap)
  );
  // next time: a load beats set-mode increments, which beat the 1 Hz advance
  always_comb begin
    hr_d = hr;
    min_d = min;
    sec_d = sec;
    wrap_d = 1'b0;
    if (xfer) begin
      if (load_ok) begin
        hr_d = load_hr;
        min_d = load_min;
        sec_d = load_sec;
      end
    end else if (mode == SET) begin
      if (inc_hr) hr_d = HR_W'(wrap_inc({1'b0, hr}, {1'b0, MAX_HR}));
      if (inc_min) begin
        min_d = wrap_inc(min, MAX_MIN);
        sec_d = '0;
      end
    end else if (wrap) begin
      sec_d = wrap_inc(sec, MAX_SEC);
      if (sec == MAX_SEC) begin
        min_d = wrap_inc(min, MAX_MIN);
        if (min == MAX_MIN) begin
          hr_d = HR_W'(wrap_inc({1'b0, hr}, {1'b0, MAX_HR}));
          wrap_d = hr == MAX_HR;
        end
      end
    end
  end
  // register time and pulse outputs; ready rises on the first edge out of reset
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      hr <= '0;
      min <= '0;
      sec <= '0;
      tick_1hz <= 1'b0;
      day_wrap <= 1'b0;
      load_err <= 1'b0;
      load_ready <= 1'b0;
    end else begin
      hr <= hr_d;
      min <= min_d;
      sec <= sec_d;
      tick_1hz <= wrap;
      day_wrap <= wrap_d;
      load_err <= xfer && !load_ok;
      load_ready <= 1'b1;
    end
endmodule
